// File: rtl/adc_axil_pkg.sv
// ---------------------------------------------------------------------------
// adc_axil_pkg
// Shared constants for the ADC AXI4-Lite register block: register word
// indices (byte address bits [4:2]), STATUS bit positions and the AXI
// response codes, plus small decode helpers used by adc_axil_regs.
// ---------------------------------------------------------------------------
package adc_axil_pkg;

    // Word indices decoded from ADDR[4:2]; 6 and 7 are unmapped
    localparam logic [2:0] IDX_REG0   = 3'd0;
    localparam logic [2:0] IDX_REG1   = 3'd1;
    localparam logic [2:0] IDX_REG2   = 3'd2;
    localparam logic [2:0] IDX_REG3   = 3'd3;
    localparam logic [2:0] IDX_SAMPLE = 3'd4;
    localparam logic [2:0] IDX_STATUS = 3'd5;

    // STATUS word layout
    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_OVERRUN_BIT = 1;
    localparam int STATUS_COUNT_LSB   = 16;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // REG0..REG3 and STATUS accept writes; SAMPLE and unmapped words do not
    function automatic logic isWritable(input logic [2:0] idx);
        return (idx <= IDX_REG3) || (idx == IDX_STATUS);
    endfunction

    // Everything up to and including STATUS is readable
    function automatic logic isReadable(input logic [2:0] idx);
        return idx <= IDX_STATUS;
    endfunction

endpackage

// File: rtl/adc_axil_regs.sv
// ---------------------------------------------------------------------------
// adc_axil_regs
// AXI4-Lite slave exposing four RW control registers, the latest ADC sample
// and a STATUS word (pending / overrun / 16-bit sample count), with a
// registered sample-ready interrupt gated by REG0[0].
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   S_AXI_AW*             write address channel (AWPROT ignored)
//   S_AXI_W*              write data channel
//   S_AXI_B*              write response channel
//   S_AXI_AR*, S_AXI_R*   read address / read data channels (ARPROT ignored)
//   adc_data, adc_valid   ADC sample and its one-cycle strobe
//   ctrl_out              REG0 contents
//   irq                   pending AND REG0[0], registered
// ---------------------------------------------------------------------------
module adc_axil_regs
    import adc_axil_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 5,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADC_WIDTH  = 12
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                S_AXI_AWPROT,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                S_AXI_ARPROT,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    input  logic [C_ADC_WIDTH-1:0]    adc_data,
    input  logic                      adc_valid,
    output logic [C_DATA_WIDTH-1:0]   ctrl_out,
    output logic                      irq
);

    // Holding registers for the independent AW and W channels
    logic                      awFull_q, awFull_d;
    logic [2:0]                awIdx_q,  awIdx_d;
    logic                      wFull_q,  wFull_d;
    logic [C_DATA_WIDTH-1:0]   wData_q,  wData_d;
    logic [C_DATA_WIDTH/8-1:0] wStrb_q,  wStrb_d;

    // Response channels
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q,  bresp_d;
    logic                      rvalid_q, rvalid_d;
    logic [1:0]                rresp_q,  rresp_d;
    logic [C_DATA_WIDTH-1:0]   rdata_q,  rdata_d;

    // Register file and ADC state
    logic [C_DATA_WIDTH-1:0]   regs_q [4];
    logic [C_DATA_WIDTH-1:0]   regs_d [4];
    logic [C_ADC_WIDTH-1:0]    sample_q, sample_d;
    logic                      pending_q, pending_d;
    logic                      overrun_q, overrun_d;
    logic [15:0]               count_q,   count_d;
    logic                      irq_q,     irq_d;

    logic                      awHs, wHs, arHs, bHs, rHs;
    logic                      commit;
    logic                      sampleRead;
    logic                      overrunClr;
    logic [2:0]                arIdx;
    logic [C_DATA_WIDTH-1:0]   sampleExt;
    logic [C_DATA_WIDTH-1:0]   statusWord;
    logic [C_DATA_WIDTH-1:0]   rdMux;
    logic [1:0]                rdResp;
    logic                      unusedBits;

    // PROT and the byte-lane address bits carry no meaning here
    assign unusedBits = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWPROT, S_AXI_ARPROT};

    assign S_AXI_AWREADY = !awFull_q;
    assign S_AXI_WREADY  = !wFull_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign ctrl_out      = regs_q[0];
    assign irq           = irq_q;

    assign awHs   = S_AXI_AWVALID && !awFull_q;
    assign wHs    = S_AXI_WVALID  && !wFull_q;
    assign arHs   = S_AXI_ARVALID && !rvalid_q;
    assign bHs    = bvalid_q && S_AXI_BREADY;
    assign rHs    = rvalid_q && S_AXI_RREADY;
    assign arIdx  = S_AXI_ARADDR[4:2];

    // A write only commits once both halves are captured and the previous
    // response has been taken, so BRESP never gets overwritten
    assign commit     = awFull_q && wFull_q && !bvalid_q;
    assign sampleRead = arHs && (arIdx == IDX_SAMPLE);
    assign overrunClr = commit && (awIdx_q == IDX_STATUS) &&
                        wStrb_q[0] && wData_q[STATUS_OVERRUN_BIT];

    // Zero-extend the sample without a zero-width replication at full width
    always_comb begin
        sampleExt = '0;
        sampleExt[C_ADC_WIDTH-1:0] = sample_q;
    end

    always_comb begin
        statusWord = '0;
        statusWord[STATUS_PENDING_BIT]     = pending_q;
        statusWord[STATUS_OVERRUN_BIT]     = overrun_q;
        statusWord[STATUS_COUNT_LSB +: 16] = count_q;
    end

    // Read decode; returns pre-update values when a sample lands in the
    // same cycle, which is what makes a coincident SAMPLE read see the old one
    always_comb begin
        rdMux  = '0;
        rdResp = isReadable(arIdx) ? RESP_OKAY : RESP_SLVERR;
        case (arIdx)
            IDX_REG0, IDX_REG1, IDX_REG2, IDX_REG3: rdMux = regs_q[arIdx[1:0]];
            IDX_SAMPLE:                             rdMux = sampleExt;
            IDX_STATUS:                             rdMux = statusWord;
            default:                                rdMux = '0;
        endcase
    end

    // Write path: holding registers, byte-strobed commit, B channel
    always_comb begin
        awFull_d = awFull_q;
        awIdx_d  = awIdx_q;
        wFull_d  = wFull_q;
        wData_d  = wData_q;
        wStrb_d  = wStrb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        regs_d   = regs_q;

        if (awHs) begin
            awFull_d = 1'b1;
            awIdx_d  = S_AXI_AWADDR[4:2];
        end else if (commit) begin
            awFull_d = 1'b0;
        end

        if (wHs) begin
            wFull_d = 1'b1;
            wData_d = S_AXI_WDATA;
            wStrb_d = S_AXI_WSTRB;
        end else if (commit) begin
            wFull_d = 1'b0;
        end

        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = isWritable(awIdx_q) ? RESP_OKAY : RESP_SLVERR;
            if (awIdx_q <= IDX_REG3) begin
                for (int b = 0; b < C_DATA_WIDTH/8; b++) begin
                    if (wStrb_q[b]) begin
                        regs_d[awIdx_q[1:0]][8*b +: 8] = wData_q[8*b +: 8];
                    end
                end
            end
        end else if (bHs) begin
            bvalid_d = 1'b0;
        end
    end

    // Read path: one-cycle latency, payload held until RREADY
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (arHs) begin
            rvalid_d = 1'b1;
            rdata_d  = rdMux;
            rresp_d  = rdResp;
        end else if (rHs) begin
            rvalid_d = 1'b0;
        end
    end

    // ADC capture. A new sample always wins over a SAMPLE read clearing
    // pending, and an overrun set wins over a W1C clear in the same cycle
    always_comb begin
        sample_d  = sample_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        irq_d     = pending_q && regs_q[0][0];

        if (sampleRead) begin
            pending_d = 1'b0;
        end
        if (overrunClr) begin
            overrun_d = 1'b0;
        end
        if (adc_valid) begin
            sample_d  = adc_data;
            pending_d = 1'b1;
            count_d   = count_q + 16'd1;
            if (pending_q && !sampleRead) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awFull_q  <= 1'b0;
            awIdx_q   <= '0;
            wFull_q   <= 1'b0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            sample_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            awFull_q  <= awFull_d;
            awIdx_q   <= awIdx_d;
            wFull_q   <= wFull_d;
            wData_q   <= wData_d;
            wStrb_q   <= wStrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
            sample_q  <= sample_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_adc_axil_regs.sv
// ---------------------------------------------------------------------------
// tb_adc_axil_regs
// Directed scenarios followed by randomized AXI4-Lite / ADC traffic. A
// behavioural model of the register map produces the expected response for
// every transaction; the expected value is queued when the transaction is
// issued and a monitor compares it when the DUT completes the handshake.
// ---------------------------------------------------------------------------
module tb_adc_axil_regs;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic [31:0] ctrl_out;
    logic        irq;

    adc_axil_regs #(
        .C_ADDR_WIDTH(5),
        .C_DATA_WIDTH(32),
        .C_ADC_WIDTH (12)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWPROT (S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARPROT (S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .ctrl_out     (ctrl_out),
        .irq          (irq)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int fails  = 0;
    int bSeen  = 0;
    int rSeen  = 0;

    // Scoreboard queues: {resp} for B, {resp, data} for R
    logic [1:0]  bQ [$];
    logic [33:0] rQ [$];

    // Behavioural model of the register map
    logic [31:0] mRegs [4];
    logic [11:0] mSample;
    logic        mPending;
    logic        mOverrun;
    logic [15:0] mCount;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: timed out waiting for handshake at %0t", name, $time);
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 4; i++) mRegs[i] = 32'h0;
        mSample  = 12'h0;
        mPending = 1'b0;
        mOverrun = 1'b0;
        mCount   = 16'h0;
    endfunction

    function automatic logic [1:0] modelWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int w;
        w = int'(addr[4:2]);
        if (w < 4) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mRegs[w][8*b +: 8] = data[8*b +: 8];
            end
            return 2'b00;
        end
        if (w == 5) begin
            if (strb[0] && data[1]) mOverrun = 1'b0;
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic void modelRead(input logic [4:0] addr, output logic [31:0] d, output logic [1:0] r);
        int w;
        w = int'(addr[4:2]);
        r = 2'b00;
        d = 32'h0;
        if (w < 4) begin
            d = mRegs[w];
        end else if (w == 4) begin
            d = {20'h0, mSample};
            mPending = 1'b0;
        end else if (w == 5) begin
            d = {mCount, 14'h0, mOverrun, mPending};
        end else begin
            r = 2'b10;
        end
    endfunction

    function automatic void modelAdc(input logic [11:0] s);
        if (mPending) mOverrun = 1'b1;
        mPending = 1'b1;
        mSample  = s;
        mCount   = mCount + 16'd1;
    endfunction

    // Monitor: compares whatever the DUT hands over against the queue head
    always @(negedge ACLK) begin
        logic [1:0]  eb;
        logic [33:0] er;
        if (!ARESET && S_AXI_BVALID && S_AXI_BREADY) begin
            if (bQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL bresp_unexpected: got resp %0d with nothing expected", S_AXI_BRESP);
            end else begin
                eb = bQ.pop_front();
                checkOutput("bresp", 32'(S_AXI_BRESP), 32'(eb));
            end
            bSeen++;
        end
        if (!ARESET && S_AXI_RVALID && S_AXI_RREADY) begin
            if (rQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL rdata_unexpected: got 0x%08h with nothing expected", S_AXI_RDATA);
            end else begin
                er = rQ.pop_front();
                checkOutput("rdata", S_AXI_RDATA, er[31:0]);
                checkOutput("rresp", 32'(S_AXI_RRESP), 32'(er[33:32]));
            end
            rSeen++;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic driveAw(input logic [4:0] addr);
        int n;
        n = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_AWPROT  = 3'($urandom_range(0, 7));
        S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        while (!S_AXI_AWREADY && n < 50) begin
            n++;
            @(negedge ACLK);
        end
        if (!S_AXI_AWREADY) reportTimeout("awready");
        tick();
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic driveW(input logic [31:0] data, input logic [3:0] strb);
        int n;
        n = 0;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        while (!S_AXI_WREADY && n < 50) begin
            n++;
            @(negedge ACLK);
        end
        if (!S_AXI_WREADY) reportTimeout("wready");
        tick();
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic waitB(input logic [1:0] exp, input int hold);
        int n;
        int seen0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin
            n++;
            tick();
        end
        if (!S_AXI_BVALID) begin
            reportTimeout("bvalid");
            if (bQ.size() > 0) void'(bQ.pop_front());
            return;
        end
        repeat (hold) begin
            checkOutput("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
            checkOutput("bresp_hold", 32'(S_AXI_BRESP), 32'(exp));
            tick();
        end
        seen0 = bSeen;
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        #1;
        if (bSeen == seen0) reportTimeout("bresp_handshake");
        tick();
        S_AXI_BREADY = 1'b0;
        checkOutput("bvalid_clear", 32'(S_AXI_BVALID), 32'd0);
    endtask

    task automatic waitR(input logic [33:0] exp, input int hold);
        int n;
        int seen0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin
            n++;
            tick();
        end
        if (!S_AXI_RVALID) begin
            reportTimeout("rvalid");
            if (rQ.size() > 0) void'(rQ.pop_front());
            return;
        end
        repeat (hold) begin
            checkOutput("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
            checkOutput("rdata_hold", S_AXI_RDATA, exp[31:0]);
            checkOutput("rresp_hold", 32'(S_AXI_RRESP), 32'(exp[33:32]));
            tick();
        end
        seen0 = rSeen;
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        #1;
        if (rSeen == seen0) reportTimeout("rdata_handshake");
        tick();
        S_AXI_RREADY = 1'b0;
        checkOutput("rvalid_clear", 32'(S_AXI_RVALID), 32'd0);
    endtask

    // skew > 0: W leads AW by skew cycles; skew < 0: AW leads
    task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int skew, input int hold);
        logic [1:0] exp;
        int awDelay;
        int wDelay;
        awDelay = (skew > 0) ? skew : 0;
        wDelay  = (skew < 0) ? -skew : 0;
        exp = modelWrite(addr, data, strb);
        bQ.push_back(exp);
        fork
            begin
                repeat (awDelay) tick();
                driveAw(addr);
            end
            begin
                repeat (wDelay) tick();
                driveW(data, strb);
            end
        join
        waitB(exp, hold);
    endtask

    // withAdc puts an ADC strobe in the same cycle as the AR handshake
    task automatic axiRead(input logic [4:0] addr, input int hold, input bit withAdc, input logic [11:0] s);
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        modelRead(addr, d, r);
        if (withAdc) modelAdc(s);
        rQ.push_back({r, d});
        n = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARPROT  = 3'($urandom_range(0, 7));
        S_AXI_ARVALID = 1'b1;
        if (withAdc) begin
            adc_data  = s;
            adc_valid = 1'b1;
        end
        @(negedge ACLK);
        while (!S_AXI_ARREADY && n < 50) begin
            n++;
            @(negedge ACLK);
        end
        if (!S_AXI_ARREADY) reportTimeout("arready");
        tick();
        S_AXI_ARVALID = 1'b0;
        adc_valid     = 1'b0;
        waitR({r, d}, hold);
    endtask

    task automatic adcPulse(input logic [11:0] s);
        modelAdc(s);
        adc_data  = s;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic checkIrqAndCtrl();
        repeat (2) tick();
        checkOutput("irq", 32'(irq), 32'(mPending & mRegs[0][0]));
        checkOutput("ctrl_out", ctrl_out, mRegs[0]);
    endtask

    task automatic applyReset();
        ARESET = 1'b1;
        repeat (3) tick();
        ARESET = 1'b0;
        modelReset();
    endtask

    // STATUS overrun clear whose commit cycle coincides with a new sample
    task automatic writeClearRace(input logic [11:0] s);
        logic [1:0] exp;
        exp = modelWrite(5'h14, 32'h2, 4'hF);
        bQ.push_back(exp);
        S_AXI_AWADDR  = 5'h14;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'h2;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        adcPulse(s);
        waitB(exp, 0);
    endtask

    task automatic applyStimulus(input int nOps);
        for (int i = 0; i < nOps; i++) begin
            int op;
            logic [4:0] a;
            op = int'($urandom_range(0, 9));
            a  = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if (op < 4) begin
                axiWrite(a, $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
            end else if (op < 7) begin
                axiRead(a, int'($urandom_range(0, 3)), 1'b0, 12'h0);
            end else if (op < 9) begin
                adcPulse(12'($urandom));
            end else begin
                checkIrqAndCtrl();
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        adc_data      = '0;
        adc_valid     = 1'b0;
        modelReset();

        $display("[TB] reset state");
        applyReset();
        checkOutput("rst_awready", 32'(S_AXI_AWREADY), 32'd1);
        checkOutput("rst_wready", 32'(S_AXI_WREADY), 32'd1);
        checkOutput("rst_arready", 32'(S_AXI_ARREADY), 32'd1);
        checkOutput("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        checkOutput("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        checkOutput("rst_bresp", 32'(S_AXI_BRESP), 32'd0);
        checkOutput("rst_rresp", 32'(S_AXI_RRESP), 32'd0);
        checkOutput("rst_rdata", S_AXI_RDATA, 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_ctrl_out", ctrl_out, 32'd0);

        $display("[TB] REG0..REG3 write/readback");
        for (int i = 0; i < 4; i++) axiWrite(5'(4 * i), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) axiRead(5'(4 * i), 0, 1'b0, 12'h0);

        $display("[TB] W leads AW, partial strobe");
        axiWrite(5'h04, 32'h11223344, 4'hF, 0, 0);
        axiWrite(5'h04, 32'hAABBCCDD, 4'b0011, 3, 0);
        axiRead(5'h04, 0, 1'b0, 12'h0);

        $display("[TB] single sample");
        adcPulse(12'hABC);
        axiRead(5'h10, 0, 1'b0, 12'h0);
        axiRead(5'h14, 0, 1'b0, 12'h0);

        $display("[TB] reset during write commit");
        S_AXI_AWADDR  = 5'h04;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'hDEADBEEF;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        applyReset();
        repeat (3) begin
            checkOutput("abort_bvalid", 32'(S_AXI_BVALID), 32'd0);
            tick();
        end
        axiRead(5'h04, 0, 1'b0, 12'h0);

        $display("[TB] overrun and W1C");
        adcPulse(12'h123);
        adcPulse(12'h456);
        axiRead(5'h14, 0, 1'b0, 12'h0);
        axiWrite(5'h14, 32'h2, 4'hF, 0, 0);
        axiRead(5'h14, 0, 1'b0, 12'h0);

        $display("[TB] error responses");
        axiWrite(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0);
        axiRead(5'h18, 0, 1'b0, 12'h0);
        axiWrite(5'h1C, 32'hFFFFFFFF, 4'hF, -2, 0);
        for (int i = 0; i < 4; i++) axiRead(5'(4 * i), 0, 1'b0, 12'h0);

        $display("[TB] interrupt timing");
        axiWrite(5'h00, 32'h1, 4'hF, 0, 0);
        axiRead(5'h10, 0, 1'b0, 12'h0);
        checkIrqAndCtrl();
        adcPulse(12'h777);
        @(negedge ACLK);
        checkOutput("irq_not_yet", 32'(irq), 32'd0);
        @(negedge ACLK);
        checkOutput("irq_asserted", 32'(irq), 32'd1);
        tick();

        $display("[TB] stalled responses");
        axiWrite(5'h08, 32'h5A5A0F0F, 4'hF, 0, 10);
        axiRead(5'h08, 10, 1'b0, 12'h0);
        axiRead(5'h18, 10, 1'b0, 12'h0);

        $display("[TB] coincident sample read and ADC strobe");
        axiRead(5'h10, 0, 1'b1, 12'h9A5);
        axiRead(5'h14, 0, 1'b0, 12'h0);
        checkIrqAndCtrl();

        $display("[TB] overrun set beats clear");
        adcPulse(12'h3C3);
        writeClearRace(12'h0F0);
        axiRead(5'h14, 0, 1'b0, 12'h0);

        $display("[TB] randomized traffic");
        applyStimulus(250);
        checkIrqAndCtrl();
        axiRead(5'h14, 0, 1'b0, 12'h0);

        repeat (3) tick();
        checkOutput("b_queue_drained", 32'(bQ.size()), 32'd0);
        checkOutput("r_queue_drained", 32'(rQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adc_axil_regs.md
ADC_AXIL_REGS -- requirements
Module: adc_axil_regs

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 5, the AXI4-Lite byte-address width.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 32, the AXI4-Lite data width; no other value is supported.
REQ-003 SHALL have parameter C_ADC_WIDTH, default 12, the ADC sample width (1..32).
REQ-004 SHALL have one clock; reset is synchronous and active-high; ports: ACLK in 1, rising-edge clock; ARESET in 1, synchronous active-high reset.
REQ-005 SHALL have write-address ports: S_AXI_AWADDR in C_ADDR_WIDTH, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1.
REQ-006 SHALL have write-data ports: S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1.
REQ-007 SHALL have write-response ports: S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-008 SHALL have read ports: S_AXI_ARADDR in C_ADDR_WIDTH, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-009 SHALL have ADC ports: adc_data in C_ADC_WIDTH (sample), adc_valid in 1 (one-cycle strobe), ctrl_out out 32 (REG0 contents), irq out 1 (sample-ready interrupt).

Function
REQ-010 SHALL decode word address ADDR[4:2]: 0-3 REG0..REG3 RW; 4 SAMPLE RO (zero-extended sample); 5 STATUS (bit0 pending RO, bit1 overrun W1C, bits[31:16] sample count RO); 6-7 unmapped.
REQ-011 SHALL accept AW and W independently; each has a one-entry holding register; AWREADY/WREADY high only while its holding register is empty.
REQ-012 SHALL perform the write in the cycle both holding registers are full and BVALID is low, applying WSTRB per byte, and assert BVALID on the next cycle.
REQ-013 SHALL hold BVALID and BRESP stable until BREADY; holding registers free on write commit, so a new AW/W may be accepted while B waits.
REQ-014 SHALL return BRESP OKAY (00) for REG0-3 and STATUS, SLVERR (10) for SAMPLE and unmapped words, without state change on SLVERR.
REQ-015 SHALL assert ARREADY when RVALID is low; on the AR handshake, register RDATA/RRESP and assert RVALID the next cycle (1-cycle latency); hold them until RREADY.
REQ-016 SHALL return RDATA 0 with RRESP SLVERR for unmapped reads, OKAY otherwise.
REQ-017 SHALL on adc_valid latch adc_data into SAMPLE, set pending, increment the 16-bit sample count (wrapping 0xFFFF->0x0000), and set overrun if pending was already set.
REQ-018 SHALL clear pending on an AR handshake to SAMPLE; if adc_valid occurs in the same cycle, return the old sample, keep pending set, and do not set overrun.
REQ-019 SHALL clear overrun on a STATUS write with WDATA[1]=1 and WSTRB[0]=1; a simultaneous set wins over clear.
REQ-020 SHALL drive irq = pending AND REG0[0], registered (one cycle after pending changes).

Reset
REQ-021 SHALL on ARESET clear REG0-3, SAMPLE, pending, overrun, count, holding registers, BVALID, RVALID, RDATA, BRESP, RRESP, and irq; AWREADY/WREADY/ARREADY are 1 from the first cycle after reset.
REQ-022 SHALL abandon any in-flight transaction when ARESET is asserted mid-operation, with no register update.

Structure
REQ-023 SHALL place register word indices, the STATUS bit positions, and the RESP_OKAY/RESP_SLVERR constants in a shared package adc_axil_pkg.
REQ-024 SHALL be a single module; no sub-module.

Verification
REQ-025 SHALL check: write 0x1,0x2,0x3,0x4 to 0x00-0x0C, then read back -> data equal, all RESP OKAY.
REQ-026 SHALL check: W presented 3 cycles before AW at 0x04, WSTRB=0011, WDATA=0xAABBCCDD over 0x11223344 -> read 0x1122CCDD.
REQ-027 SHALL check: adc_valid with 0xABC, then read 0x10 -> 0x00000ABC, STATUS pending cleared afterwards, count=1.
REQ-028 SHALL check: two adc_valid without a read -> STATUS=0x00020003; write 0x2 to 0x14 -> 0x00020001.
REQ-029 SHALL check: write to 0x10 and read of 0x18 -> BRESP 10, RRESP 10 with RDATA 0; REG values unchanged.
REQ-030 SHALL check: BREADY/RREADY held low 10 cycles -> BVALID/RVALID and payload stable; REG0[0]=1 with pending -> irq=1 one cycle later.
